// File: rtl/biquad_pkg.sv
// Shared widths, types and the round/saturate finalize step for the
// three-band biquad cascade engine.
package biquad_pkg;

    localparam int DATA_W     = 16;
    localparam int ACC_W      = 40;
    localparam int COEFF_FRAC = 14;

    typedef struct packed {
        logic signed [DATA_W-1:0] b0;
        logic signed [DATA_W-1:0] b1;
        logic signed [DATA_W-1:0] b2;
        logic signed [DATA_W-1:0] a1;
        logic signed [DATA_W-1:0] a2;
    } coeff_set_t;

    typedef enum logic [1:0] {LOW, MID, HIGH} stage_t;

    typedef enum logic [1:0] {IDLE, MAC, WRITEBACK, DONE} eng_state_t;

    // Unity gain: b0 = 1.0 in Q2.14, every other tap zero.
    localparam coeff_set_t COEFF_PASSTHRU = '{b0: DATA_W'(1 << COEFF_FRAC), default: '0};

    localparam logic signed [ACC_W-1:0] ROUND_K =
        {{(ACC_W-COEFF_FRAC){1'b0}}, 1'b1, {(COEFF_FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = (acc + ROUND_K) >>> COEFF_FRAC;
        if (shifted > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return shifted[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/biquad_cascade_engine_if.sv
// Sample, coefficient and result signals between the SPI coefficient
// receiver side (master) and the biquad engine (slave).
interface biquad_cascade_engine_if;

    logic                                    sample_valid;
    logic signed [biquad_pkg::DATA_W-1:0]    sample_in;
    logic signed [biquad_pkg::DATA_W-1:0]    low_b0, low_b1, low_b2, low_a1, low_a2;
    logic signed [biquad_pkg::DATA_W-1:0]    mid_b0, mid_b1, mid_b2, mid_a1, mid_a2;
    logic signed [biquad_pkg::DATA_W-1:0]    high_b0, high_b1, high_b2, high_a1, high_a2;
    logic                                    coeff_update;
    logic signed [biquad_pkg::DATA_W-1:0]    sample_out;
    logic                                    out_valid;
    logic                                    busy;
    logic                                    overrun;

    modport master (
        output sample_valid, sample_in, coeff_update,
        output low_b0, low_b1, low_b2, low_a1, low_a2,
        output mid_b0, mid_b1, mid_b2, mid_a1, mid_a2,
        output high_b0, high_b1, high_b2, high_a1, high_a2,
        input  sample_out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_valid, sample_in, coeff_update,
        input  low_b0, low_b1, low_b2, low_a1, low_a2,
        input  mid_b0, mid_b1, mid_b2, mid_a1, mid_a2,
        input  high_b0, high_b1, high_b2, high_a1, high_a2,
        output sample_out, out_valid, busy, overrun
    );

endinterface

// File: rtl/biquad_mac.sv
// Shared signed 16x16 multiply with add/subtract select into a wide
// accumulator; clear takes priority over accumulate.
module biquad_mac
    import biquad_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     sub_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod     = a_i * b_i;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            acc_q <= '0;
        else if (clr_i)
            acc_q <= '0;
        else if (en_i)
            acc_q <= sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/biquad_cascade_engine.sv
// Time-multiplexed low/mid/high Direct-Form-I biquad cascade on one MAC,
// with double-buffered coefficients so a sample never sees a mid-flight update.
module biquad_cascade_engine
    import biquad_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    biquad_cascade_engine_if.slave bus
);

    eng_state_t               state_q;
    stage_t                   stage_q;
    logic [2:0]               tap_q;
    coeff_set_t [2:0]         active_q;
    coeff_set_t [2:0]         shadow_q;
    logic                     pending_q;
    logic signed [DATA_W-1:0] x_cur_q;
    logic signed [DATA_W-1:0] x1_q [3];
    logic signed [DATA_W-1:0] x2_q [3];
    logic signed [DATA_W-1:0] y1_q [3];
    logic signed [DATA_W-1:0] y2_q [3];
    logic signed [DATA_W-1:0] sample_out_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     overrun_q;

    coeff_set_t [2:0]         coeff_in;
    coeff_set_t               cs;
    logic [1:0]               sidx;
    logic signed [DATA_W-1:0] op_coeff;
    logic signed [DATA_W-1:0] op_data;
    logic                     mac_sub;
    logic                     mac_en;
    logic                     mac_clr;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] y_d;

    assign coeff_in[0] = '{b0: bus.low_b0,  b1: bus.low_b1,  b2: bus.low_b2,  a1: bus.low_a1,  a2: bus.low_a2};
    assign coeff_in[1] = '{b0: bus.mid_b0,  b1: bus.mid_b1,  b2: bus.mid_b2,  a1: bus.mid_a1,  a2: bus.mid_a2};
    assign coeff_in[2] = '{b0: bus.high_b0, b1: bus.high_b1, b2: bus.high_b2, a1: bus.high_a1, a2: bus.high_a2};

    assign sidx = stage_q;
    assign cs   = active_q[sidx];

    // a-taps are stored un-negated, so the MAC subtracts them.
    always_comb begin
        op_coeff = cs.b0;
        op_data  = x_cur_q;
        mac_sub  = 1'b0;
        case (tap_q)
            3'd1: begin op_coeff = cs.b1; op_data = x1_q[sidx]; end
            3'd2: begin op_coeff = cs.b2; op_data = x2_q[sidx]; end
            3'd3: begin op_coeff = cs.a1; op_data = y1_q[sidx]; mac_sub = 1'b1; end
            3'd4: begin op_coeff = cs.a2; op_data = y2_q[sidx]; mac_sub = 1'b1; end
            default: ;
        endcase
    end

    assign mac_en  = (state_q == MAC);
    assign mac_clr = ((state_q == IDLE) && bus.sample_valid) || (state_q == WRITEBACK);
    assign y_d     = sat_round(acc);

    biquad_mac u_mac (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .sub_i (mac_sub),
        .a_i   (op_coeff),
        .b_i   (op_data),
        .acc_o (acc)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            stage_q      <= LOW;
            tap_q        <= '0;
            active_q     <= {3{COEFF_PASSTHRU}};
            shadow_q     <= {3{COEFF_PASSTHRU}};
            pending_q    <= 1'b0;
            x_cur_q      <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (bus.sample_valid && (state_q != IDLE))
                overrun_q <= 1'b1;
            if (bus.coeff_update) begin
                if (state_q == IDLE) begin
                    active_q <= coeff_in;
                end else begin
                    shadow_q  <= coeff_in;
                    pending_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (bus.sample_valid) begin
                        x_cur_q <= bus.sample_in;
                        stage_q <= LOW;
                        tap_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    if (tap_q == 3'd4)
                        state_q <= WRITEBACK;
                    else
                        tap_q <= tap_q + 3'd1;
                end
                WRITEBACK: begin
                    x2_q[sidx] <= x1_q[sidx];
                    x1_q[sidx] <= x_cur_q;
                    y2_q[sidx] <= y1_q[sidx];
                    y1_q[sidx] <= y_d;
                    x_cur_q    <= y_d;
                    if (stage_q == HIGH) begin
                        sample_out_q <= y_d;
                        state_q      <= DONE;
                    end else begin
                        stage_q <= (stage_q == LOW) ? MID : HIGH;
                        tap_q   <= '0;
                        state_q <= MAC;
                    end
                end
                DONE: begin
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                    // An update landing on this very edge is newer than the shadow.
                    if (bus.coeff_update)
                        active_q <= coeff_in;
                    else if (pending_q)
                        active_q <= shadow_q;
                    pending_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sample_out = sample_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule
